imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning output immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, meaning output buffer entries; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_inst valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_inst this cycle.
REQ-007 SHALL have port in_inst  input  32  raw RV instruction word.
REQ-008 SHALL have port out_valid  output  1  out_* fields hold a result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port out_imm  output  XLEN  extended immediate.
REQ-011 SHALL have port out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 reserved (never driven).
REQ-012 SHALL have port out_illegal  output  1  opcode not recognised.

Function
REQ-013 Transfers: input on in_valid&&in_ready; output on out_valid&&out_ready.
REQ-014 Decode by opcode inst[6:0]:
- I: 0000011, 0010011, 1100111; 0011011 only when XLEN=64.
- S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
- 1110011: Z if inst[14]=1, else NONE.
- 0110011 (and 0111011 when XLEN=64): NONE.
- Anything else: illegal.
REQ-015 I/S/B/J immediates SHALL be sign-extended from inst[31] to XLEN using standard RV bit placement; B and J bit 0 SHALL be 0.
REQ-016 U immediate SHALL be {inst[31:12],12'b0}, sign-extended to XLEN when XLEN=64.
REQ-017 Z immediate SHALL be inst[19:15] zero-extended to XLEN.
REQ-018 NONE and illegal SHALL give out_imm=0 and out_fmt=0; out_illegal=1 only for illegal.
REQ-019 Latency SHALL be 1 cycle: word accepted in cycle N is visible on out_* from cycle N+1 when the buffer was empty.
REQ-020 Buffer state SHALL be EMPTY, ONE or TWO (TWO only when DEPTH=2), giving the occupancy count.
REQ-021 Buffer transitions:
- push only: count+1.
- pop only: count-1.
- push and pop together: count unchanged.
REQ-022 in_ready SHALL be registered, equal to (count<DEPTH), with no combinational path from out_ready.
REQ-023 out_valid SHALL equal (count!=0).
REQ-024 out_* SHALL come from the oldest entry and hold stable while out_valid&&!out_ready.
REQ-025 Results SHALL leave in input order with no loss or duplication.
REQ-026 With out_ready held high, throughput SHALL be one result per cycle.
REQ-027 in_inst SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-028 On rst_n low, state SHALL go to EMPTY at once and asynchronously; in-flight entries are discarded.
REQ-029 During reset: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, in_ready=0.
REQ-030 in_ready SHALL rise on the first clk edge after rst_n is released.

Structure
REQ-031 Package imm_gen_pkg SHALL hold the opcode constants, the 3-bit fmt encoding, and the XLEN legality check.
REQ-032 Decode SHALL be a combinational sub-module imm_decode(inst -> imm, fmt, illegal), parameterised by XLEN.
REQ-033 imm_gen_pipe SHALL hold only the buffer and the handshake logic.

Verification
REQ-034 XLEN=32, in 0xF0000067 -> next cycle out_imm=0xFFFFFF00, fmt=1; with XLEN=64 -> 0xFFFFFFFFFFFFFF00.
REQ-035 In 0x00000043 -> illegal=1, imm=0, fmt=0. In 0x00000003 -> imm=0, fmt=1, illegal=0.
REQ-036 Per-format checks:
- 0xFE000EE3 -> 0xFFFFFFFC, fmt 3.
- 0x0080006F -> 0x00000008, fmt 5.
- 0x12345037 -> 0x12345000, fmt 4.
- 0x000FE073 -> 0x0000001F, fmt 6.
REQ-037 Backpressure: DEPTH=2, out_ready=0, offer A,B,C back-to-back -> A,B accepted and in_ready=0 while C is held; raise out_ready -> A,B,C out in order, out_* stable while stalled.
REQ-038 Streaming: out_ready=1, 16 consecutive valid words -> 16 results on consecutive cycles, count never exceeds 1.
REQ-039 Assert rst_n mid-stream with count=2 -> out_valid=0 immediately; after release, the first new word is output and no old entry reappears.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared decode constants for the immediate generator: opcodes, fmt codes, parameter checks.
// No logic; imported by imm_decode and imm_gen_pipe.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // Code 7 is reserved and never produced.
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth == 1) || (depth == 2);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// RV immediate decode: opcode -> extended immediate, format code, illegal flag.
// Latency: purely combinational.
// Backpressure: none; the caller owns all flow control.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    // Every format fits in 32 bits with bit 31 as its sign (zimm has bit 31 clear),
    // so one sign-extension step covers both XLEN values.
    logic [31:0] imm32;

    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OP_IMM32: begin
                if (RV64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                if (inst[14]) begin
                    fmt   = FMT_Z;
                    imm32 = {27'b0, inst[19:15]};
                end
            end
            OPC_OP: ;
            OPC_OP32: illegal = !RV64;
            default:  illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a DEPTH-entry in-order output buffer.
// Latency: 1 cycle from accepted word to out_* when the buffer is empty.
// Backpressure: in_ready is registered (count < DEPTH), never combinational from out_ready.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("imm_gen_pipe: DEPTH must be 1 or 2");
    end

    // Buffer state doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ONE    = 2'd1;
    localparam logic [1:0] ST_TWO    = 2'd2;
    localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    logic [1:0]      state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [XLEN-1:0] imm_q [DEPTH];
    logic [XLEN-1:0] imm_d [DEPTH];
    logic [2:0]      fmt_q [DEPTH];
    logic [2:0]      fmt_d [DEPTH];
    logic            ill_q [DEPTH];
    logic            ill_d [DEPTH];
    logic [1:0]      wr_cnt;
    logic            push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        fmt_d   = fmt_q;
        ill_d   = ill_q;
        case ({push, pop})
            2'b10:   state_d = (state_q == ST_EMPTY) ? ST_ONE : ST_TWO;
            2'b01:   state_d = (state_q == ST_TWO) ? ST_ONE : ST_EMPTY;
            default: state_d = state_q;
        endcase
        // Entry 0 is always the oldest; a pop shifts the rest down.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                imm_d[i] = imm_q[i+1];
                fmt_d[i] = fmt_q[i+1];
                ill_d[i] = ill_q[i+1];
            end
        end
        wr_cnt = state_q - {1'b0, pop};
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(wr_cnt)) begin
                    imm_d[i] = dec_imm;
                    fmt_d[i] = dec_fmt;
                    ill_d[i] = dec_ill;
                end
            end
        end
        in_ready_d = (state_d < DEPTH_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= FMT_NONE;
                ill_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            imm_q      <= imm_d;
            fmt_q      <= fmt_d;
            ill_q      <= ill_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_imm     = out_valid ? imm_q[0] : '0;
    assign out_fmt     = out_valid ? fmt_q[0] : FMT_NONE;
    assign out_illegal = out_valid && ill_q[0];

endmodule
